// File: rtl/prod_accum.sv
// prod_accum: sums LEN unsigned products from the multiplier into a saturating
// ACC_W-bit accumulator and presents each frame total on a valid/ready port.
//
// state | meaning
// ------+---------------------------------------------------------------
// ACC   | accepting products, building the frame sum in acc
// HOLD  | frame total held on acc_out/ovf until the consumer takes it
module prod_accum #(
    parameter int N     = 8,
    parameter int LEN   = 4,
    parameter int ACC_W = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2*N-1:0]   p,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             clr,
    output logic [ACC_W-1:0] acc_out,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    // Sized to hold LEN itself so the count never wraps before the handshake clears it.
    localparam int CNT_W = $clog2(LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;

    logic             accept;
    logic [ACC_W:0]   sum;
    logic             sum_ovf;
    logic [ACC_W-1:0] sum_sat;

    // Ready only in ACC and never while reset is held; built from registered state.
    always_comb begin
        in_ready = (state == ACC) && !rst;
        accept   = in_valid && in_ready;
    end

    // One extra bit catches the carry out; a set carry clamps the result to all-ones.
    always_comb begin
        sum     = {1'b0, acc} + {{(ACC_W + 1 - 2*N){1'b0}}, p};
        sum_ovf = sum[ACC_W];
        sum_sat = sum_ovf ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    end

    // Frame FSM: accumulate in ACC, park the total in HOLD until it is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACC;
            acc       <= '0;
            cnt       <= '0;
            acc_out   <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ACC: begin
                    if (clr) begin
                        // A clear wins over a same-cycle product; that product is dropped.
                        acc <= '0;
                        cnt <= '0;
                        ovf <= 1'b0;
                    end else if (accept) begin
                        acc <= sum_sat;
                        cnt <= cnt + CNT_W'(1);
                        ovf <= ovf | sum_ovf;
                        if (cnt == CNT_LAST) begin
                            acc_out   <= sum_sat;
                            out_valid <= 1'b1;
                            state     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    // clr is ignored here so a finished total can't be lost mid-handshake.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        acc       <= '0;
                        cnt       <= '0;
                        ovf       <= 1'b0;
                        state     <= ACC;
                    end
                end
                default: begin
                    state <= ACC;
                end
            endcase
        end
    end

endmodule
